// File: rtl/note_sequencer.sv
// note_sequencer: walks a song memory one entry at a time, dispatches each
// note to its channel via a trigger/ready handshake, and holds for one tempo
// step after entries flagged step_end.
//
// Build option NOTE_SEQ_LOOP_EN: when defined, the end-of-song sentinel
// restarts playback at address 0 instead of halting in END.

package note_sequencer_pkg;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned CH_N   = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned FREQ_W = 11;

    // One song-memory word
    typedef struct packed {
        logic [CH_W-1:0]   channel;
        logic              step_end;
        logic [LEN_W-1:0]  length;
        logic [FREQ_W-1:0] freq;
    } song_entry_t;

endpackage

module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TICKS_PER_STEP = 1032192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic [CH_N-1:0]      ch_trig,
    input  logic [CH_N-1:0]      ch_ready,
    output logic [FREQ_W-1:0]    ch_freq,
    output logic [LEN_W-1:0]     ch_len,
    output logic                 playing,
    output logic                 done
);

    localparam int unsigned      CNT_W     = 20;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TICKS_PER_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_HOLD,
        S_END
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  tick_cnt;
    logic              step_end_q;

    song_entry_t       entry_c;
    logic              sentinel_c;
    logic              accept_c;
    logic [ADDR_W-1:0] addr_inc_c;

    // Entry decode, handshake detect and next address
    assign entry_c    = song_entry_t'(mem_data);
    assign sentinel_c = entry_c.step_end
                        && (entry_c.length == LEN_W'(0))
                        && (entry_c.freq == FREQ_W'(0));
    assign accept_c   = |(ch_trig & ch_ready);
    assign addr_inc_c = addr + ADDR_W'(1);

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            tick_cnt   <= '0;
            step_end_q <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            ch_trig    <= '0;
            ch_freq    <= '0;
            ch_len     <= '0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            mem_rd <= 1'b0;
            done   <= 1'b0;

            if (stop) begin
                // Abort drops any pending trigger immediately
                state   <= S_IDLE;
                ch_trig <= '0;
                playing <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            addr     <= '0;
                            mem_addr <= '0;
                            mem_rd   <= 1'b1;
                            playing  <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end

                    S_FETCH: begin
                        state <= S_DECODE;
                    end

                    S_DECODE: begin
                        step_end_q <= entry_c.step_end;
                        if (sentinel_c) begin
                            done <= 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                            addr     <= '0;
                            mem_addr <= '0;
                            mem_rd   <= 1'b1;
                            state    <= S_FETCH;
`else
                            playing <= 1'b0;
                            state   <= S_END;
`endif
                        end else begin
                            ch_trig <= CH_N'(1) << entry_c.channel;
                            ch_freq <= entry_c.freq;
                            ch_len  <= entry_c.length;
                            state   <= S_DISPATCH;
                        end
                    end

                    S_DISPATCH: begin
                        if (accept_c) begin
                            ch_trig <= '0;
                            addr    <= addr_inc_c;
                            if (step_end_q) begin
                                tick_cnt <= '0;
                                state    <= S_HOLD;
                            end else begin
                                mem_addr <= addr_inc_c;
                                mem_rd   <= 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                    end

                    S_HOLD: begin
                        if (tick_cnt == HOLD_LAST) begin
                            mem_addr <= addr;
                            mem_rd   <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end

                    S_END: begin
                        if (start) begin
                            addr     <= '0;
                            mem_addr <= '0;
                            mem_rd   <= 1'b1;
                            playing  <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        ch_trig <= '0;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, song-memory address width.
REQ-002 SHALL have parameter TICKS_PER_STEP, default 1032192, clk cycles per step hold (63/256 s at 2^22 Hz); legal range 1..2^20-1.
REQ-003 SHALL have port clk  input  1  system clock, 2^22 Hz.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin playback at address 0.
REQ-006 SHALL have port stop  input  1  abort playback.
REQ-007 SHALL have port mem_rd  output  1  song-memory read strobe.
REQ-008 SHALL have port mem_addr  output  ADDR_W  song-memory address.
REQ-009 SHALL have port mem_data  input  20  entry, valid the cycle after mem_rd: [19:18] channel, [17] step_end, [16:11] length, [10:0] frequency.
REQ-010 SHALL have port ch_trig  output  4  one-hot channel trigger request.
REQ-011 SHALL have port ch_ready  input  4  per-channel trigger accept.
REQ-012 SHALL have port ch_freq  output  11  frequency for the triggered channel.
REQ-013 SHALL have port ch_len  output  6  length for the triggered channel.
REQ-014 SHALL have port playing  output  1  high in every state except IDLE and END.
REQ-015 SHALL have port done  output  1  one-cycle pulse on end-of-song.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, DISPATCH, HOLD, END.
REQ-017 IDLE: start=1 -> addr=0, next FETCH; otherwise stay.
REQ-018 FETCH: mem_rd=1 and mem_addr=addr for exactly one cycle; next DECODE.
REQ-019 DECODE: register mem_data; entry step_end=1, length=0, frequency=0 is end-of-song sentinel -> done=1, next END; any other entry -> DISPATCH.
REQ-020 DISPATCH: ch_trig bit [channel]=1, ch_freq/ch_len = registered fields, held stable until ch_ready[channel]=1 in the same cycle (handshake); ch_ready of other channels ignored.
REQ-021 On handshake: addr <= addr+1 modulo 2^ADDR_W (wrap to 0 at max); step_end=1 -> HOLD, else FETCH.
REQ-022 HOLD: 20-bit tempo counter cleared on entry; HOLD lasts exactly TICKS_PER_STEP cycles, then FETCH.
REQ-023 END: stay until start=1 (restart from addr 0, FETCH) or stop=1 (IDLE).
REQ-024 stop=1 in any state -> IDLE next cycle, ch_trig=0 and mem_rd=0 from that cycle; an unaccepted trigger is dropped.
REQ-025 start and stop both high: stop wins; start while playing=1 is ignored.
REQ-026 Minimum per-entry cost: 3 cycles (FETCH, DECODE, DISPATCH with ch_ready already high).
REQ-027 ch_trig SHALL be 0 outside DISPATCH; ch_freq/ch_len hold last value otherwise.

Reset
REQ-028 reset SHALL dominate all inputs: state=IDLE, addr=0, tempo counter=0, mem_rd=0, mem_addr=0, ch_trig=0, ch_freq=0, ch_len=0, playing=0, done=0 on the next edge, including mid-DISPATCH or mid-HOLD.

Configuration
REQ-029 Macro NOTE_SEQ_LOOP_EN: when defined, end-of-song in DECODE pulses done, sets addr=0 and goes to FETCH (continuous loop, playing stays 1); when undefined, behaviour is REQ-019/REQ-023 (halt in END).

Verification (TICKS_PER_STEP=4 unless stated)
REQ-030 Song {addr0: ch1,step_end=0,len=10,freq=0x123; addr1: ch2,step_end=1,len=5,freq=0x456; addr2: sentinel}, ch_ready=4'hF, start pulse -> ch_trig=4'b0010 with 0x123/10, then 4'b0100 with 0x456/5, 4 HOLD cycles, done pulse, END, playing=0.
REQ-031 Hold ch_ready[1]=0 for 7 cycles during DISPATCH -> ch_trig=4'b0010 and fields stable all 7 cycles, addr unchanged until accept.
REQ-032 Assert stop mid-HOLD and separately mid-DISPATCH -> IDLE next cycle, ch_trig=0, mem_rd=0, no further fetches.
REQ-033 reset in DISPATCH, and start+stop simultaneously in IDLE -> all outputs at REQ-028 values; IDLE retained, no fetch.
REQ-034 ADDR_W=2, four non-sentinel entries with step_end=1 -> mem_addr sequence 0,1,2,3,0; HOLD exactly TICKS_PER_STEP cycles each (also check TICKS_PER_STEP=1).
REQ-035 With NOTE_SEQ_LOOP_EN, REQ-030 song -> done pulse then mem_addr=0 fetch, playing stays 1; without it, halt in END.
